// File: rtl/remote_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : remote_key_pkg
//  Desc     : Shared constants for the IR remote key-event sequencer:
//             event types, one-hot FSM states and Avalon register map.
//  Revision : 1.0  initial release
// ============================================================================
package remote_key_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_HOLD    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_PRESSED = 4'b0010;
    localparam logic [3:0] ST_HELD    = 4'b0100;
    localparam logic [3:0] ST_SWITCH  = 4'b1000;

    localparam logic [2:0] ADDR_EVENT  = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_CMD    = 3'd3;

    function automatic logic [9:0] ev_word(input logic [1:0] ev_type, input logic [7:0] code);
        return {ev_type, code};
    endfunction

endpackage : remote_key_pkg
`default_nettype wire

// File: rtl/remote_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : remote_key_fifo
//  Desc     : Synchronous event FIFO with occupancy count, full/empty flags,
//             flush, and a one-cycle pulse for pushes dropped while full.
//  Revision : 1.0  initial release
// ============================================================================
module remote_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_DEPTH);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_overflow = i_push && !w_do_push && !i_flush;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule : remote_key_fifo
`default_nettype wire

// File: rtl/remote_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : remote_key_ctrl
//  Desc     : Turns NEC decoder code/repeat pulses into PRESS/HOLD/REPEAT/
//             RELEASE events queued for Avalon-MM reads, with level IRQ.
//             Define REMOTE_KEY_AUTOREPEAT_EN to emit REPEAT events while held.
//  Revision : 1.0  initial release
// ============================================================================
module remote_key_ctrl
    import remote_key_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int RELEASE_MS   = 120,
    parameter int HOLD_REPEATS = 4,
    parameter int AUTO_REPEATS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    input  logic        repeat_valid,
    input  logic [2:0]  avl_address,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    input  logic        avl_read,
    output logic [31:0] avl_readdata,
    output logic        irq
);

    localparam int c_REL_CNT = CLK_FREQ / 1000 * RELEASE_MS;
    localparam int c_TMR_W   = (c_REL_CNT > 1) ? $clog2(c_REL_CNT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(c_REL_CNT - 1);
    localparam int c_REP_MAX = (HOLD_REPEATS > AUTO_REPEATS) ? HOLD_REPEATS : AUTO_REPEATS;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_HOLD_N = c_REP_W'(HOLD_REPEATS);
`ifdef REMOTE_KEY_AUTOREPEAT_EN
    localparam logic [c_REP_W-1:0] c_AUTO_N = c_REP_W'(AUTO_REPEATS);
`endif
    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [7:0]         r_cur_code;
    logic [7:0]         w_code_nxt;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic [c_REP_W-1:0] w_rep_inc;
    logic [c_TMR_W-1:0] r_timer;
    logic               w_active;
    logic               w_push;
    logic [9:0]         w_push_data;
    logic               r_en;
    logic               r_irq_en;
    logic               r_overflow;
    logic               w_pop;
    logic               w_cmd_wr;
    logic               w_flush;
    logic               w_ovf;
    logic [9:0]         w_pop_data;
    logic [c_CW-1:0]    w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_unused;

    assign w_active  = (r_state == ST_PRESSED) || (r_state == ST_HELD);
    assign w_rep_inc = r_rep_cnt + 1'b1;
    assign w_unused  = &{1'b0, avl_writedata[31:2], 1'b0};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_cur_code <= '0;
            r_rep_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_code <= w_code_nxt;
            r_rep_cnt  <= w_rep_nxt;
        end
    end

    // The key_valid branch is tested before expiry, so a simultaneous
    // expiry never produces a second RELEASE.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_cur_code;
        w_rep_nxt   = r_rep_cnt;
        w_push      = 1'b0;
        w_push_data = '0;
        if (!r_en) begin
            w_state_nxt = ST_IDLE;
            w_rep_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        w_push      = 1'b1;
                        w_push_data = ev_word(EV_PRESS, key_code);
                        w_code_nxt  = key_code;
                        w_rep_nxt   = '0;
                        w_state_nxt = ST_PRESSED;
                    end
                end
                ST_PRESSED, ST_HELD: begin
                    if (key_valid) begin
                        w_push      = 1'b1;
                        w_push_data = ev_word(EV_RELEASE, r_cur_code);
                        w_code_nxt  = key_code;
                        w_rep_nxt   = '0;
                        w_state_nxt = ST_SWITCH;
                    end else if (repeat_valid) begin
                        if (r_state == ST_PRESSED) begin
                            if (w_rep_inc == c_HOLD_N) begin
                                w_push      = 1'b1;
                                w_push_data = ev_word(EV_HOLD, r_cur_code);
                                w_rep_nxt   = '0;
                                w_state_nxt = ST_HELD;
                            end else begin
                                w_rep_nxt = w_rep_inc;
                            end
                        end
`ifdef REMOTE_KEY_AUTOREPEAT_EN
                        else if (w_rep_inc == c_AUTO_N) begin
                            w_push      = 1'b1;
                            w_push_data = ev_word(EV_REPEAT, r_cur_code);
                            w_rep_nxt   = '0;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
`endif
                    end else if (r_timer == '0) begin
                        w_push      = 1'b1;
                        w_push_data = ev_word(EV_RELEASE, r_cur_code);
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SWITCH: begin
                    w_push      = 1'b1;
                    w_push_data = ev_word(EV_PRESS, r_cur_code);
                    w_rep_nxt   = '0;
                    w_state_nxt = ST_PRESSED;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer <= '0;
        end else if (r_en && (key_valid || repeat_valid)) begin
            r_timer <= c_TMR_LOAD;
        end else if (w_active && (r_timer != '0)) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    assign w_pop    = avl_read && (avl_address == ADDR_EVENT);
    assign w_cmd_wr = avl_write && (avl_address == ADDR_CMD);
    assign w_flush  = w_cmd_wr && avl_writedata[0];

    remote_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_pop_data  (w_pop_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_overflow  (w_ovf)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_overflow <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (avl_write && (avl_address == ADDR_CTRL)) begin
                r_en     <= avl_writedata[0];
                r_irq_en <= avl_writedata[1];
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (w_cmd_wr && avl_writedata[1]) begin
                r_overflow <= 1'b0;
            end
            irq <= r_irq_en && !w_empty;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            avl_readdata <= '0;
        end else if (avl_read) begin
            case (avl_address)
                ADDR_EVENT:  avl_readdata <= w_empty ? 32'd0 : {1'b1, 21'd0, w_pop_data};
                ADDR_STATUS: avl_readdata <= {24'd0, r_overflow, 5'(w_count), w_full, w_empty};
                ADDR_CTRL:   avl_readdata <= {30'd0, r_irq_en, r_en};
                default:     avl_readdata <= '0;
            endcase
        end
    end

endmodule : remote_key_ctrl
`default_nettype wire
